// File: rtl/cb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cb_pkg
// Purpose  : Shared widths and FSM state encoding for the circular-buffer
//            block read sequencer and its helpers.
// Revision : 1.0  initial release
// ============================================================================
package cb_pkg;

  localparam int CB_DW    = 18;               // sample width (signed)
  localparam int CB_LANES = 4;                // samples per block
  localparam int CB_AW    = 12;               // relative block address width
  localparam int CB_SUMW  = 20;               // lane-sum width (signed)
  localparam int CB_BW    = CB_DW * CB_LANES; // block data width

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2
  } cb_state_e;

endpackage
`default_nettype wire

// File: rtl/cb_sum4.sv
`default_nettype none
// ============================================================================
// Module   : cb_sum4
// Purpose  : Combinational signed sum of the four 18-bit lanes of one block.
//            Each lane is sign-extended to the 20-bit result width first, so
//            the sum of four full-scale lanes cannot overflow.
// Ports    : data_i [71:0] four packed signed lanes, lane 0 in [17:0]
//            sum_o  [19:0] signed sum of all lanes
// Revision : 1.0  initial release
// ============================================================================
module cb_sum4
  import cb_pkg::*;
(
  input  logic [CB_BW-1:0]   data_i,
  output logic [CB_SUMW-1:0] sum_o
);

  always_comb begin
    sum_o = '0;
    for (int l = 0; l < CB_LANES; l++) begin
      sum_o = sum_o + {{(CB_SUMW-CB_DW){data_i[l*CB_DW + CB_DW-1]}},
                       data_i[l*CB_DW +: CB_DW]};
    end
  end

endmodule
`default_nettype wire

// File: rtl/cb_rd_seq.sv
`default_nettype none
// ============================================================================
// Module   : cb_rd_seq
// Purpose  : Reads NBLK consecutive 4-sample blocks from a circular buffer
//            read port. Each block address is held for two cycles (ISSUE,
//            CAPTURE) so a registered-read RAM has its data ready when the
//            block is captured at the end of CAPTURE.
// Config   : CB_RD_SEQ_SUM_EN - when defined, a registered signed sum of the
//            four lanes is produced alongside dout; otherwise sum is tied 0
//            and no adder exists. The port list is the same either way.
// Ports    : clock    master clock, rising edge
//            reset    synchronous active-high reset
//            start    one-cycle request for a read sequence
//            addrin   [11:0] relative block address (0 while idle)
//            dbuf     [71:0] buffer read data, newest sample in [71:54]
//            dout     [71:0] registered block data
//            dvalid   dout holds a new block this cycle
//            dfirst   qualifies dvalid for block 0
//            dlast    qualifies dvalid for block NBLK-1
//            busy     sequence in progress
//            done     one-cycle pulse with the last dvalid
//            overrun  sticky: a start arrived while busy and was dropped
//            sum      [19:0] registered signed lane sum of dout
// Revision : 1.0  initial release
// ============================================================================
module cb_rd_seq
  import cb_pkg::*;
#(
  parameter int NBLK = 256
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  output logic [CB_AW-1:0]   addrin,
  input  logic [CB_BW-1:0]   dbuf,
  output logic [CB_BW-1:0]   dout,
  output logic               dvalid,
  output logic               dfirst,
  output logic               dlast,
  output logic               busy,
  output logic               done,
  output logic               overrun,
  output logic [CB_SUMW-1:0] sum
);

  // Compared in the counter's own 12 bits so NBLK=4096 terminates at 4095.
  localparam logic [CB_AW-1:0] LAST_BLK = CB_AW'(NBLK - 1);

  cb_state_e        state_q, state_d;
  logic [CB_AW-1:0] blk_q, blk_d;
  logic [CB_BW-1:0] dout_q;
  logic             dvalid_q, dfirst_q, dlast_q, done_q, overrun_q;
  logic             capture;
  logic             is_last;

  assign is_last = (blk_q == LAST_BLK);

  always_comb begin
    state_d = state_q;
    blk_d   = blk_q;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ISSUE;
          blk_d   = '0;
        end
      end
      ISSUE: begin
        state_d = CAPTURE;
      end
      CAPTURE: begin
        capture = 1'b1;
        if (is_last) begin
          state_d = IDLE;
        end else begin
          state_d = ISSUE;
          blk_d   = blk_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      blk_q     <= '0;
      dout_q    <= '0;
      dvalid_q  <= 1'b0;
      dfirst_q  <= 1'b0;
      dlast_q   <= 1'b0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      blk_q    <= blk_d;
      dvalid_q <= capture;
      dfirst_q <= capture && (blk_q == '0);
      dlast_q  <= capture && is_last;
      done_q   <= capture && is_last;
      if (capture) begin
        dout_q <= dbuf;
      end
      // A start seen while busy is dropped; only the flag records it.
      if (start && (state_q != IDLE)) begin
        overrun_q <= 1'b1;
      end
    end
  end

  assign busy    = (state_q != IDLE);
  assign addrin  = busy ? blk_q : '0;
  assign dout    = dout_q;
  assign dvalid  = dvalid_q;
  assign dfirst  = dfirst_q;
  assign dlast   = dlast_q;
  assign done    = done_q;
  assign overrun = overrun_q;

`ifdef CB_RD_SEQ_SUM_EN
  logic [CB_SUMW-1:0] lane_sum;
  logic [CB_SUMW-1:0] sum_q;

  cb_sum4 u_sum4 (
    .data_i (dbuf),
    .sum_o  (lane_sum)
  );

  // Loaded on the same edge as dout so the pair always matches.
  always_ff @(posedge clock) begin
    if (reset) begin
      sum_q <= '0;
    end else if (capture) begin
      sum_q <= lane_sum;
    end
  end

  assign sum = sum_q;
`else
  assign sum = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cb_rd_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_cb_rd_seq
// Purpose  : Self-checking bench for cb_rd_seq. Two instances (NBLK=4 and
//            NBLK=1) share start/reset; each reads its own registered-read
//            buffer model. A reference model computes every output per cycle
//            from the offset since the accepted start.
// Revision : 1.0  initial release
// ============================================================================
module tb_cb_rd_seq;

`ifdef CB_RD_SEQ_SUM_EN
  localparam bit SUM_EN = 1'b1;
`else
  localparam bit SUM_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        st  = 1'b0;
  logic [11:0] addr0, addr1;
  logic [71:0] dbuf0, dbuf1, dout0, dout1;
  logic        dv0, df0, dl0, bz0, dn0, ov0;
  logic        dv1, df1, dl1, bz1, dn1, ov1;
  logic [19:0] sum0, sum1;

  cb_rd_seq #(.NBLK(4)) u_dut0 (
    .clock(clk), .reset(rst), .start(st), .addrin(addr0), .dbuf(dbuf0),
    .dout(dout0), .dvalid(dv0), .dfirst(df0), .dlast(dl0), .busy(bz0),
    .done(dn0), .overrun(ov0), .sum(sum0)
  );

  cb_rd_seq #(.NBLK(1)) u_dut1 (
    .clock(clk), .reset(rst), .start(st), .addrin(addr1), .dbuf(dbuf1),
    .dout(dout1), .dvalid(dv1), .dfirst(df1), .dlast(dl1), .busy(bz1),
    .done(dn1), .overrun(ov1), .sum(sum1)
  );

  // Circular buffer with one-cycle registered read.
  logic [71:0] mem [0:15];
  always @(posedge clk) begin
    dbuf0 <= mem[addr0[3:0]];
    dbuf1 <= mem[addr1[3:0]];
  end

  // Reference model state, one slot per instance.
  int          nb    [2] = '{4, 1};
  bit          m_act [2];
  int          m_d   [2];   // cycles since accepted start
  bit          m_ovr [2];
  logic [71:0] m_dout[2];
  logic [19:0] m_sum [2];

  int errors = 0;
  int checks = 0;

  function automatic logic [19:0] lsum(logic [71:0] w);
    int s;
    logic signed [17:0] lane;
    s = 0;
    for (int l = 0; l < 4; l++) begin
      lane = w[l*18 +: 18];
      s += int'(lane);
    end
    return s[19:0];
  endfunction

  function automatic bit model_busy(int i);
    return m_act[i] && (m_d[i] >= 1) && (m_d[i] <= 2*nb[i]);
  endfunction

  task automatic chk(string tag, logic [71:0] obs, logic [71:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(logic s, logic r);
    bit          bzn [2];
    bit          e_busy, e_dv, e_first, e_last;
    int          e_addr, blk;
    logic [11:0] o_addr;
    logic [71:0] o_dout;
    logic [19:0] o_sum;
    logic        o_bz, o_dv, o_df, o_dl, o_dn, o_ov;
    st = s;
    rst = r;
    for (int i = 0; i < 2; i++) bzn[i] = model_busy(i);
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      e_dv = 1'b0;
      blk  = 0;
      if (r) begin
        m_act[i] = 1'b0; m_d[i] = 0; m_ovr[i] = 1'b0;
        m_dout[i] = '0;  m_sum[i] = '0;
      end else begin
        if (m_act[i]) m_d[i]++;
        if (s) begin
          if (bzn[i]) m_ovr[i] = 1'b1;
          else begin
            m_act[i] = 1'b1;
            m_d[i]   = 1;
          end
        end
        if (m_act[i] && m_d[i] > 2*nb[i] + 1) m_act[i] = 1'b0;
        e_dv = m_act[i] && (m_d[i] >= 3) && (m_d[i] % 2 == 1);
        if (e_dv) begin
          blk       = (m_d[i] - 3) / 2;
          m_dout[i] = mem[blk];
          m_sum[i]  = SUM_EN ? lsum(mem[blk]) : 20'd0;
        end
      end
      e_busy  = model_busy(i);
      e_addr  = e_busy ? (m_d[i] - 1) / 2 : 0;
      e_first = e_dv && (blk == 0);
      e_last  = e_dv && (blk == nb[i] - 1);
      if (i == 0) begin
        o_addr = addr0; o_dout = dout0; o_sum = sum0; o_bz = bz0;
        o_dv = dv0; o_df = df0; o_dl = dl0; o_dn = dn0; o_ov = ov0;
      end else begin
        o_addr = addr1; o_dout = dout1; o_sum = sum1; o_bz = bz1;
        o_dv = dv1; o_df = df1; o_dl = dl1; o_dn = dn1; o_ov = ov1;
      end
      chk($sformatf("u%0d busy", i),    72'(o_bz),   72'(e_busy));
      chk($sformatf("u%0d addrin", i),  72'(o_addr), 72'(e_addr));
      chk($sformatf("u%0d dvalid", i),  72'(o_dv),   72'(e_dv));
      chk($sformatf("u%0d dfirst", i),  72'(o_df),   72'(e_first));
      chk($sformatf("u%0d dlast", i),   72'(o_dl),   72'(e_last));
      chk($sformatf("u%0d done", i),    72'(o_dn),   72'(e_last));
      chk($sformatf("u%0d overrun", i), 72'(o_ov),   72'(m_ovr[i]));
      chk($sformatf("u%0d dout", i),    o_dout,      m_dout[i]);
      chk($sformatf("u%0d sum", i),     72'(o_sum),  72'(m_sum[i]));
    end
  endtask

  initial begin
    logic [71:0] exp_last;
    logic [71:0] exp_first;
    bit          s, r, wrote;

    // Samples 1..16, block 0 holds the newest four.
    for (int b = 0; b < 16; b++) begin
      if (b < 4)
        mem[b] = {18'(16 - 4*b), 18'(15 - 4*b), 18'(14 - 4*b), 18'(13 - 4*b)};
      else
        mem[b] = {$urandom, $urandom, $urandom};
    end
    for (int i = 0; i < 2; i++) begin
      m_act[i] = 1'b0; m_d[i] = 0; m_ovr[i] = 1'b0;
      m_dout[i] = '0;  m_sum[i] = '0;
    end

    // Reset, including reset winning over a simultaneous start.
    step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    step(1'b0, 1'b0);

    // Basic sequence.
    step(1'b1, 1'b0);
    repeat (11) step(1'b0, 1'b0);
    exp_last  = {18'd4, 18'd3, 18'd2, 18'd1};
    exp_first = {18'd16, 18'd15, 18'd14, 18'd13};
    chk("basic last block", dout0, exp_last);
    chk("nblk1 only block", dout1, exp_first);

    // Overrun: second start four cycles into a running sequence.
    step(1'b1, 1'b0);
    repeat (3) step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    repeat (8) step(1'b0, 1'b0);
    chk("overrun sticky", 72'(ov0), 72'd1);
    step(1'b0, 1'b1);

    // Back-to-back: second start lands in the done cycle.
    step(1'b1, 1'b0);
    repeat (8) step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    repeat (10) step(1'b0, 1'b0);

    // Lane-sum corner values in block 0.
    mem[0] = {18'd131071, 18'd131071, 18'h20000, 18'd5};
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    repeat (10) step(1'b0, 1'b0);

    // Reset in cycle 5 of a run, then a clean restart.
    step(1'b1, 1'b0);
    repeat (4) step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    repeat (3) step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    repeat (10) step(1'b0, 1'b0);

    // Randomized traffic; buffer rewritten only while both are idle.
    for (int n = 0; n < 500; n++) begin
      wrote = 1'b0;
      if (!model_busy(0) && !model_busy(1) && ($urandom_range(0, 3) == 0)) begin
        mem[$urandom_range(0, 3)] = {$urandom, $urandom, $urandom};
        wrote = 1'b1;
      end
      r = ($urandom_range(0, 99) == 0);
      s = !wrote && ($urandom_range(0, 4) == 0);
      step(s, r);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cb_rd_seq.md
CB_RD_SEQ -- requirements
Module: cb_rd_seq

Interface
REQ-001 The block SHALL have parameter NBLK, default 256, giving the number of 4-sample blocks read per sequence (legal range 1..4096).
REQ-002 The block SHALL have port clock, input, 1 bit: master clock, active on the rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: master reset, synchronous, active-high.
REQ-004 The block SHALL have port start, input, 1 bit: single-cycle pulse requesting one read sequence.
REQ-005 The block SHALL have port addrin, output, 12 bits: relative block address driven to the circular buffer read port.
REQ-006 The block SHALL have port dbuf, input, 72 bits: circular buffer read data, newest sample in [71:54] and oldest in [17:0].
REQ-007 The block SHALL have port dout, output, 72 bits: registered block data.
REQ-008 The block SHALL have port dvalid, output, 1 bit: dout holds a new block this cycle.
REQ-009 The block SHALL have ports dfirst and dlast, outputs, 1 bit each: dvalid qualifiers marking block 0 and block NBLK-1.
REQ-010 The block SHALL have ports busy and done, outputs, 1 bit each: sequence in progress, and a single-cycle pulse on completion.
REQ-011 The block SHALL have port overrun, output, 1 bit: sticky flag set when start is rejected.
REQ-012 The block SHALL have port sum, output, 20 bits signed: registered sum of the four 18-bit signed lanes of dout.

Function
REQ-013 The block SHALL use FSM states IDLE, ISSUE and CAPTURE, with busy = (state != IDLE).
REQ-014 IDLE SHALL go to ISSUE on start, clearing block counter blk to 0; otherwise it SHALL remain in IDLE.
REQ-015 ISSUE SHALL go to CAPTURE unconditionally.
REQ-016 addrin SHALL equal blk during ISSUE and during CAPTURE, so each address is held for exactly two cycles.
REQ-017 In CAPTURE the block SHALL register dbuf into dout and go to IDLE if blk == NBLK-1; otherwise it SHALL increment blk and go to ISSUE.
REQ-018 Latency: with start high in cycle 0, dvalid SHALL be high in cycles 3, 5, ..., 2*NBLK+1 and busy SHALL be high in cycles 1..2*NBLK.
REQ-019 dvalid SHALL be low in every other cycle.
REQ-020 dfirst SHALL be high only with the first dvalid of a sequence.
REQ-021 dlast and done SHALL be high only with the last dvalid of a sequence.
REQ-022 With NBLK=1, dfirst, dlast and done SHALL all be high in cycle 3.
REQ-023 The end-of-sequence test SHALL compare blk against NBLK-1 in 12 bits, so NBLK=4096 ends at blk=4095 without counter wrap.
REQ-024 start while busy SHALL be ignored and SHALL set overrun; the running sequence SHALL continue unaffected.
REQ-025 start arriving in the same cycle as done SHALL be accepted, because state is IDLE in that cycle.
REQ-026 dout and sum SHALL hold their last values while dvalid is low.
REQ-027 When idle, addrin SHALL be 0.
REQ-028 The circular buffer SHALL NOT be written while busy is high; start SHALL be issued at least one cycle after the buffer write.

Reset
REQ-029 Reset SHALL force state IDLE and blk 0.
REQ-030 Reset SHALL clear addrin, dout, sum, dvalid, dfirst, dlast, busy, done and overrun to 0 on the next rising edge.
REQ-031 Reset mid-sequence SHALL abort the sequence with no done pulse and no further dvalid.
REQ-032 Reset SHALL take priority over start in the same cycle.

Configuration
REQ-033 With macro CB_RD_SEQ_SUM_EN defined, sum SHALL be the sign-extended sum of dbuf's four 18-bit lanes, registered with dout, so it updates in the same cycle as dout.
REQ-034 Without CB_RD_SEQ_SUM_EN, sum SHALL be tied to 0 and no adder logic SHALL be present; the port list SHALL be identical in both cases.

Structure
REQ-035 Shared package cb_pkg SHALL hold CB_DW=18, CB_LANES=4, CB_AW=12, CB_SUMW=20 and the FSM state enumeration.
REQ-036 The four-lane signed adder SHALL be a sub-module cb_sum4, instantiated only under CB_RD_SEQ_SUM_EN.

Verification
REQ-037 Scenario (basic sequence): NBLK=4, buffer preloaded with samples 1..16 (16 newest), start at cycle 0 -> addrin 0,0,1,1,2,2,3,3 in cycles 1..8; dvalid in cycles 3,5,7,9; first dout = {16,15,14,13}, last dout = {4,3,2,1}; dfirst in cycle 3; dlast and done in cycle 9.
REQ-038 Scenario (NBLK=1): start at cycle 0 -> single dvalid in cycle 3 with dfirst, dlast and done all high; busy high in cycles 1..2 only.
REQ-039 Scenario (overrun): start at cycle 0 and again at cycle 4 -> overrun high from cycle 5 until reset; exactly 4 dvalid pulses with an unchanged addrin sequence.
REQ-040 Scenario (back-to-back): second start in the done cycle -> second sequence accepted, first new dvalid 3 cycles after that start, overrun stays 0.
REQ-041 Scenario (reset mid-run): reset at cycle 5 of an NBLK=256 run -> all outputs 0 from cycle 6, no done, IDLE; a new start afterwards runs normally.
REQ-042 Scenario (sum with CB_RD_SEQ_SUM_EN): lanes {131071, 131071, -131072, 5} -> sum = 131075 with dvalid; without the macro sum = 0 throughout.
